instr_packer: RTL and testbench
===============================

// Module: instr_packer
// PURPOSE
//   Inverse of the immediate generator. Accepts decoded instruction fields plus a 32-bit immediate and packs them into a RV32I instruction word.
//   Uses the R/I/S/B/U/J bit layouts. Each word is emitted with a wrapping instruction-memory word address.
//   Sits between the boot/self-test sequencer and instruction-memory write port; 2-stage valid/ready pipeline.
// PARAMETERS
//   ADDR_W     8    width of instruction-memory word address
//   BASE_ADDR  0    address loaded at reset and on CLR
// PORTS
//   INSTR_PACK_CLOCK_50      in   1   system clock, rising edge
//   INSTR_PACK_RESET_InLow   in   1   asynchronous active-low reset
//   INSTR_PACK_Clr_In        in   1   sync: address <- BASE_ADDR, flush pipeline
//   INSTR_PACK_Valid_In      in   1   request valid
//   INSTR_PACK_Ready_Out     out  1   request accepted when Valid_In & Ready_Out
//   INSTR_PACK_Fmt_InBUS     in   3   format: 0 R,1 I,2 S,3 B,4 U,5 J; 6,7 illegal
//   INSTR_PACK_Opcode_InBUS  in   7   opcode field
//   INSTR_PACK_Rd_InBUS      in   5   rd
//   INSTR_PACK_Rs1_InBUS     in   5   rs1
//   INSTR_PACK_Rs2_InBUS     in   5   rs2
//   INSTR_PACK_Funct3_InBUS  in   3   funct3
//   INSTR_PACK_Funct7_InBUS  in   7   funct7 (R only)
//   INSTR_PACK_Imm_InBUS     in   32  immediate, byte offset, two's complement
//   INSTR_PACK_Valid_Out     out  1   output word valid
//   INSTR_PACK_Ready_In      in   1   downstream ready
//   INSTR_PACK_Ins_OutBUS    out  32  packed instruction
//   INSTR_PACK_Addr_OutBUS   out  ADDR_W  word address of Ins_OutBUS
//   INSTR_PACK_Err_Out       out  1   qualified by Valid_Out: request was illegal
//   INSTR_PACK_Wrap_Out      out  1   1-cycle pulse when address wraps to 0
// BEHAVIOUR
//   Reset (async, RESET_InLow=0): both stage valids 0, Valid_Out=0, Ins=0, Err=0, Wrap=0, Addr=BASE_ADDR; Ready_Out=1 after release.
//   Pipeline: S1 registers fields + range-check result; S2 registers packed word, error flag and address.
//   Latency 2 cycles accept->Valid_Out; throughput 1/cycle with no stall.
//   Stall: S2 holds while Valid_Out & !Ready_In; S1 advances only when S2 empty or draining.
//   Ready_Out = !s1_valid | s1_advance (combinational from Ready_In; no bubble).
//   Output regs stable while Valid_Out & !Ready_In.
//   Packing: standard RV32I layouts; imm bits taken as I/S imm[11:0], B imm[12:1], U imm[31:12], J imm[20:1]; R ignores imm.
//   Err word: Ins = 32'h00000013 (NOP), Err=1; still consumes one address.
//   Address: increments by 1 on each output handshake (Valid_Out & Ready_In); 2^ADDR_W-1 -> 0 wraps; Wrap pulses in the cycle after the wrapping handshake.
//   Clr: synchronous, overrides handshake that cycle; clears both stage valids and sets Addr=BASE_ADDR. A request offered that cycle is not accepted.
//   Illegal Fmt (6,7): Err=1 always, macro independent.
// CONFIGURATION
//   INSTR_PACK_RANGE_CHECK_EN defined: S1 flags Err if the immediate does not fit:
//     I: signed -2048..2047; if Opcode=0010011 & Funct3=011 (SLTIU), unsigned 0..4095.
//     S: signed -2048..2047.
//     B: signed -4096..4094 and even.
//     J: signed -1048576..1048574 and even.
//     U: imm[11:0] must be 0.
//   Undefined: no range/alignment check, fields truncated silently, Err only for illegal Fmt.
// STRUCTURE
//   Package instr_pack_pkg: FMT_R..FMT_J localparams, NOP word 32'h00000013, opcode/funct3 constants for SLTIU.
//   Sub-module instr_pack_range_chk (combinational, Fmt+Opcode+Funct3+Imm -> ok).
//   This sub-module is instantiated only under INSTR_PACK_RANGE_CHECK_EN.
// TESTING
//   Fmt=I, Op=0010011, rd=1, rs1=0, f3=000, imm=-1 -> Ins=0xFFF00093, Err=0, Addr=0, 2 cycles after accept.
//   Fmt=S, Op=0100011, rs1=1, rs2=2, f3=010, imm=8 -> Ins=0x0020A423, next beat Addr=1.
//   Fmt=B, Op=1100011, rs1=rs2=0, f3=000, imm=-4 -> Ins=0xFE000EE3; Fmt=U, Op=0110111, rd=5, imm=0x12345000 -> 0x123452B7.
//   With _EN: Fmt=J, imm=3 -> Ins=0x00000013, Err=1; SLTIU imm=4095 -> Err=0. Without _EN: same inputs -> Err=0.
//   Hold Ready_In=0 for 5 cycles while streaming: Ready_Out drops after 2 accepted, outputs stable, no loss/duplication after release.
//   ADDR_W=2, send 5 words -> Addr 0,1,2,3,0 with Wrap pulse once. Assert RESET_InLow mid-stream -> Valid_Out=0 immediately, Addr=BASE_ADDR.

Source files
------------

// File: rtl/instr_pack_pkg.sv
// Shared definitions for the RV32I instruction packer: format codes, the NOP
// word used for rejected requests, SLTIU decode constants and the packing function.
package instr_pack_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0] NOP_WORD   = 32'h00000013;  // addi x0, x0, 0
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0]  F3_SLTIU   = 3'b011;

    // One decoded request as it travels through stage 1.
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } req_t;

    // Format codes 6 and 7 have no encoding.
    function automatic logic fmt_legal(input logic [2:0] fmt);
        return fmt <= FMT_J;
    endfunction

    // Scatter fields and immediate bits into the standard RV32I layouts.
    function automatic logic [31:0] pack_word(input req_t r);
        logic [31:0] w;
        case (r.fmt)
            FMT_R:   w = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
            FMT_I:   w = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
            FMT_S:   w = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
            FMT_B:   w = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3,
                          r.imm[4:1], r.imm[11], r.opcode};
            FMT_U:   w = {r.imm[31:12], r.rd, r.opcode};
            FMT_J:   w = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.opcode};
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_pack_range_chk.sv
// Combinational immediate range/alignment check for the instruction packer.
// Only instantiated when INSTR_PACK_RANGE_CHECK_EN is defined.
module instr_pack_range_chk
    import instr_pack_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic        ok
);

    logic signed [31:0] simm;
    assign simm = $signed(imm);

    // Decide whether the immediate survives truncation into the chosen format.
    always_comb begin
        // NOTE: default assignment first so no path leaves ok unassigned (no latch).
        ok = 1'b1;
        case (fmt)
            FMT_I: begin
                if (opcode == OPC_OP_IMM && funct3 == F3_SLTIU)
                    ok = (imm[31:12] == 20'd0);
                else
                    ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            FMT_S:   ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            FMT_B:   ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
            FMT_J:   ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
            FMT_U:   ok = (imm[11:0] == 12'd0);
            default: ok = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_packer.sv
// RV32I instruction packer: decoded fields + immediate -> 32-bit instruction word
// with a wrapping instruction-memory word address, behind a 2-stage valid/ready pipe.
// Optional feature macro: INSTR_PACK_RANGE_CHECK_EN (immediate range/alignment check).
module instr_packer
    import instr_pack_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              INSTR_PACK_CLOCK_50,
    input  logic              INSTR_PACK_RESET_InLow,
    input  logic              INSTR_PACK_Clr_In,
    input  logic              INSTR_PACK_Valid_In,
    output logic              INSTR_PACK_Ready_Out,
    input  logic [2:0]        INSTR_PACK_Fmt_InBUS,
    input  logic [6:0]        INSTR_PACK_Opcode_InBUS,
    input  logic [4:0]        INSTR_PACK_Rd_InBUS,
    input  logic [4:0]        INSTR_PACK_Rs1_InBUS,
    input  logic [4:0]        INSTR_PACK_Rs2_InBUS,
    input  logic [2:0]        INSTR_PACK_Funct3_InBUS,
    input  logic [6:0]        INSTR_PACK_Funct7_InBUS,
    input  logic [31:0]       INSTR_PACK_Imm_InBUS,
    output logic              INSTR_PACK_Valid_Out,
    input  logic              INSTR_PACK_Ready_In,
    output logic [31:0]       INSTR_PACK_Ins_OutBUS,
    output logic [ADDR_W-1:0] INSTR_PACK_Addr_OutBUS,
    output logic              INSTR_PACK_Err_Out,
    output logic              INSTR_PACK_Wrap_Out
);

    req_t              req_in;
    req_t              s1_req;
    logic              s1_valid;
    logic              s1_err;
    logic              range_ok;
    logic              in_err;
    logic              s2_advance;
    logic              s1_advance;
    logic              accept;
    logic              out_fire;
    logic              valid_q;
    logic              err_q;
    logic              wrap_q;
    logic [31:0]       ins_q;
    logic [ADDR_W-1:0] addr_q;

    assign req_in = '{fmt:    INSTR_PACK_Fmt_InBUS,
                      opcode: INSTR_PACK_Opcode_InBUS,
                      rd:     INSTR_PACK_Rd_InBUS,
                      rs1:    INSTR_PACK_Rs1_InBUS,
                      rs2:    INSTR_PACK_Rs2_InBUS,
                      funct3: INSTR_PACK_Funct3_InBUS,
                      funct7: INSTR_PACK_Funct7_InBUS,
                      imm:    INSTR_PACK_Imm_InBUS};

`ifdef INSTR_PACK_RANGE_CHECK_EN
    instr_pack_range_chk u_range_chk (
        .fmt    (INSTR_PACK_Fmt_InBUS),
        .opcode (INSTR_PACK_Opcode_InBUS),
        .funct3 (INSTR_PACK_Funct3_InBUS),
        .imm    (INSTR_PACK_Imm_InBUS),
        .ok     (range_ok)
    );
`else
    assign range_ok = 1'b1;
`endif

    // Illegal format is always an error; range failures only when checking is built in.
    assign in_err     = !fmt_legal(INSTR_PACK_Fmt_InBUS) || !range_ok;

    // S2 can take a new word when empty or when its current word leaves this cycle.
    assign s2_advance = !valid_q || INSTR_PACK_Ready_In;
    assign s1_advance = s1_valid && s2_advance;
    assign INSTR_PACK_Ready_Out = !s1_valid || s1_advance;
    assign accept     = INSTR_PACK_Valid_In && INSTR_PACK_Ready_Out && !INSTR_PACK_Clr_In;
    assign out_fire   = valid_q && INSTR_PACK_Ready_In;

    // Stage 1: capture the request fields and the error verdict.
    always_ff @(posedge INSTR_PACK_CLOCK_50 or negedge INSTR_PACK_RESET_InLow) begin
        if (!INSTR_PACK_RESET_InLow) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            s1_valid <= 1'b0;
            s1_req   <= '0;
            s1_err   <= 1'b0;
        end else if (INSTR_PACK_Clr_In) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_req   <= req_in;
            s1_err   <= in_err;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: packed word, error flag, output address counter and wrap pulse.
    always_ff @(posedge INSTR_PACK_CLOCK_50 or negedge INSTR_PACK_RESET_InLow) begin
        if (!INSTR_PACK_RESET_InLow) begin
            // NOTE: the payload is reset as well so Ins/Err read as 0 straight out of reset.
            valid_q <= 1'b0;
            ins_q   <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
            addr_q  <= BASE_ADDR;
        end else if (INSTR_PACK_Clr_In) begin
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            addr_q  <= BASE_ADDR;
        end else begin
            wrap_q <= out_fire && (addr_q == '1);
            if (out_fire)
                addr_q <= addr_q + 1'b1;
            if (s2_advance) begin
                valid_q <= s1_valid;
                if (s1_valid) begin
                    ins_q <= s1_err ? NOP_WORD : pack_word(s1_req);
                    err_q <= s1_err;
                end
            end
        end
    end

    assign INSTR_PACK_Valid_Out   = valid_q;
    assign INSTR_PACK_Ins_OutBUS  = ins_q;
    assign INSTR_PACK_Err_Out     = err_q;
    assign INSTR_PACK_Addr_OutBUS = addr_q;
    assign INSTR_PACK_Wrap_Out    = wrap_q;

endmodule

// File: tb/tb_instr_packer.sv
// Directed testbench for instr_packer (ADDR_W=2 so address wrap is reachable quickly).
// Expected words are hand-encoded RV32I constants. Honours INSTR_PACK_RANGE_CHECK_EN.
module tb_instr_packer;

    localparam int ADDR_W = 2;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] exp_ins;
        logic        exp_err;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              valid_in = 1'b0;
    logic              ready_out;
    logic [2:0]        fmt = '0;
    logic [6:0]        opcode = '0;
    logic [4:0]        rd = '0;
    logic [4:0]        rs1 = '0;
    logic [4:0]        rs2 = '0;
    logic [2:0]        funct3 = '0;
    logic [6:0]        funct7 = '0;
    logic [31:0]       imm = '0;
    logic              valid_out;
    logic              ready_in = 1'b1;
    logic [31:0]       ins;
    logic [ADDR_W-1:0] addr;
    logic              err;
    logic              wrap;

    int                checks = 0;
    int                errors = 0;
    logic [ADDR_W-1:0] exp_addr = '0;

    always #5 clk = ~clk;

    instr_packer #(.ADDR_W(ADDR_W)) dut (
        .INSTR_PACK_CLOCK_50     (clk),
        .INSTR_PACK_RESET_InLow  (rst_n),
        .INSTR_PACK_Clr_In       (clr),
        .INSTR_PACK_Valid_In     (valid_in),
        .INSTR_PACK_Ready_Out    (ready_out),
        .INSTR_PACK_Fmt_InBUS    (fmt),
        .INSTR_PACK_Opcode_InBUS (opcode),
        .INSTR_PACK_Rd_InBUS     (rd),
        .INSTR_PACK_Rs1_InBUS    (rs1),
        .INSTR_PACK_Rs2_InBUS    (rs2),
        .INSTR_PACK_Funct3_InBUS (funct3),
        .INSTR_PACK_Funct7_InBUS (funct7),
        .INSTR_PACK_Imm_InBUS    (imm),
        .INSTR_PACK_Valid_Out    (valid_out),
        .INSTR_PACK_Ready_In     (ready_in),
        .INSTR_PACK_Ins_OutBUS   (ins),
        .INSTR_PACK_Addr_OutBUS  (addr),
        .INSTR_PACK_Err_Out      (err),
        .INSTR_PACK_Wrap_Out     (wrap)
    );

    function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] im,
                                input logic [31:0] e_ins, input logic e_err);
        vec_t v;
        v.fmt = f; v.opcode = op; v.rd = d; v.rs1 = s1; v.rs2 = s2;
        v.funct3 = f3; v.funct7 = f7; v.imm = im; v.exp_ins = e_ins; v.exp_err = e_err;
        return v;
    endfunction

    task automatic drive_req(input vec_t v);
        fmt = v.fmt; opcode = v.opcode; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.funct3; funct7 = v.funct7; imm = v.imm;
    endtask

    // Offer one request (Ready_In held high), return the word it produced, the
    // accept->Valid_Out latency in cycles and Wrap as seen in the cycle after its handshake.
    task automatic send_and_get(input vec_t v, output logic [31:0] o_ins, output logic o_err,
                                output logic [ADDR_W-1:0] o_addr, output logic o_wrap,
                                output int lat);
        int n;
        drive_req(v);
        valid_in = 1'b1;
        n = 0;
        #1;
        while (!ready_out && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        o_ins  = ins;
        o_err  = err;
        o_addr = addr;
        @(negedge clk);
        o_wrap = wrap;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (valid_out !== 1'b0 || ins !== 32'h0 || err !== 1'b0 || wrap !== 1'b0 || addr !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ins=%h err=%b wrap=%b addr=%0d, need 0/0/0/0/0",
                     valid_out, ins, err, wrap, addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready_out=%b need 1", ready_out);
        end
        exp_addr = '0;
    endtask

    task automatic test_pack();
        vec_t tbl[6];
        logic [31:0] o_ins;
        logic o_err, o_wrap;
        logic [ADDR_W-1:0] o_addr;
        int lat;
        tbl[0] = mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        tbl[1] = mk(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8,        32'h0020A423, 1'b0);
        tbl[2] = mk(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        tbl[3] = mk(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        tbl[4] = mk(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'hFFFFFFFF, 32'h402081B3, 1'b0);
        tbl[5] = mk(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,     32'h001000EF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send_and_get(tbl[i], o_ins, o_err, o_addr, o_wrap, lat);
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL pack_latency[%0d]: got %0d cycles need 2", i, lat);
            end
            checks++;
            if (o_ins !== tbl[i].exp_ins || o_err !== tbl[i].exp_err) begin
                errors++;
                $display("FAIL pack_word[%0d]: got %h err=%b need %h err=%b",
                         i, o_ins, o_err, tbl[i].exp_ins, tbl[i].exp_err);
            end
            checks++;
            if (o_addr !== exp_addr || o_wrap !== (exp_addr == 2'd3)) begin
                errors++;
                $display("FAIL pack_addr[%0d]: got addr=%0d wrap=%b need addr=%0d wrap=%b",
                         i, o_addr, o_wrap, exp_addr, (exp_addr == 2'd3));
            end
            exp_addr = exp_addr + 1'b1;
        end
    endtask

    task automatic test_range();
        vec_t tbl[7];
        logic [31:0] o_ins;
        logic o_err, o_wrap;
        logic [ADDR_W-1:0] o_addr;
        int lat;
`ifdef INSTR_PACK_RANGE_CHECK_EN
        tbl[0] = mk(3'd5, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3,        32'h00000013, 1'b1);
        tbl[4] = mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,     32'h00000013, 1'b1);
        tbl[5] = mk(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5,        32'h00000013, 1'b1);
        tbl[6] = mk(3'd4, 7'b0110111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345001, 32'h00000013, 1'b1);
`else
        tbl[0] = mk(3'd5, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3,        32'h0020006F, 1'b0);
        tbl[4] = mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,     32'h80000093, 1'b0);
        tbl[5] = mk(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5,        32'h00000263, 1'b0);
        tbl[6] = mk(3'd4, 7'b0110111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345001, 32'h12345037, 1'b0);
`endif
        tbl[1] = mk(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b011, 7'd0, 32'd4095,     32'hFFF13093, 1'b0);
        tbl[2] = mk(3'd6, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd0,        32'h00000013, 1'b1);
        tbl[3] = mk(3'd7, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'b000, 7'd0, 32'd0,        32'h00000013, 1'b1);
        for (int i = 0; i < 7; i++) begin
            send_and_get(tbl[i], o_ins, o_err, o_addr, o_wrap, lat);
            checks++;
            if (o_ins !== tbl[i].exp_ins || o_err !== tbl[i].exp_err || o_addr !== exp_addr) begin
                errors++;
                $display("FAIL range[%0d]: got %h err=%b addr=%0d need %h err=%b addr=%0d",
                         i, o_ins, o_err, o_addr, tbl[i].exp_ins, tbl[i].exp_err, exp_addr);
            end
            exp_addr = exp_addr + 1'b1;
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_w[4];
        logic [31:0] got_ins[4];
        logic [ADDR_W-1:0] got_addr[4];
        logic [ADDR_W-1:0] base;
        int accepted;
        int got;
        exp_w[0] = 32'h00100093; exp_w[1] = 32'h00200093;
        exp_w[2] = 32'h00300093; exp_w[3] = 32'h00400093;
        base = exp_addr;
        accepted = 0;
        got = 0;
        @(negedge clk);
        ready_in = 1'b0;
        fork
            begin : driver
                int dn;
                for (int i = 0; i < 4; i++) begin
                    drive_req(mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, i + 1, 32'h0, 1'b0));
                    valid_in = 1'b1;
                    dn = 0;
                    #1;
                    while (!ready_out && dn < 50) begin
                        @(negedge clk);
                        #1;
                        dn++;
                    end
                    @(negedge clk);
                    accepted++;
                end
                valid_in = 1'b0;
            end
            begin : receiver
                int rn;
                rn = 0;
                #2;
                while (!valid_out && rn < 20) begin
                    @(negedge clk);
                    #2;
                    rn++;
                end
                for (int h = 0; h < 5; h++) begin
                    if (h > 0) begin
                        @(negedge clk);
                        #2;
                    end
                    checks++;
                    if (valid_out !== 1'b1 || ins !== exp_w[0] || addr !== base) begin
                        errors++;
                        $display("FAIL stall_hold[%0d]: valid=%b ins=%h addr=%0d need 1 %h %0d",
                                 h, valid_out, ins, addr, exp_w[0], base);
                    end
                    checks++;
                    if (ready_out !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_ready[%0d]: ready_out=%b need 0", h, ready_out);
                    end
                end
                checks++;
                if (accepted != 2) begin
                    errors++;
                    $display("FAIL stall_accepted: got %0d need 2", accepted);
                end
                @(negedge clk);
                ready_in = 1'b1;
                rn = 0;
                while (got < 4 && rn < 40) begin
                    #2;
                    if (valid_out) begin
                        got_ins[got]  = ins;
                        got_addr[got] = addr;
                        got++;
                    end
                    @(negedge clk);
                    rn++;
                end
            end
        join
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d words need 4", got);
        end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (got_ins[i] !== exp_w[i] || got_addr[i] !== ADDR_W'(base + i)) begin
                errors++;
                $display("FAIL stall_drain[%0d]: got %h addr=%0d need %h addr=%0d",
                         i, got_ins[i], got_addr[i], exp_w[i], ADDR_W'(base + i));
            end
        end
        exp_addr = base + 3'd4;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clr();
        int seen;
        checks++;
        if (addr === '0) begin
            errors++;
            $display("FAIL clr_precond: addr=%0d need nonzero before clear", addr);
        end
        drive_req(mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd9, 32'h0, 1'b0));
        valid_in = 1'b1;
        @(negedge clk);
        clr = 1'b1;
        imm = 32'd10;
        @(negedge clk);
        clr = 1'b0;
        valid_in = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (valid_out) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL clr_flush: got %0d valid beats need 0", seen);
        end
        checks++;
        if (addr !== '0 || wrap !== 1'b0 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL clr_state: addr=%0d wrap=%b ready=%b need 0 0 1", addr, wrap, ready_out);
        end
        exp_addr = '0;
    endtask

    task automatic test_wrap();
        logic [31:0] o_ins;
        logic o_err, o_wrap;
        logic [ADDR_W-1:0] o_addr;
        logic [ADDR_W-1:0] exp_seq[5];
        int lat;
        int pulses;
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2; exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            send_and_get(mk(3'd4, 7'b0110111, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00001000 * (i + 1),
                            32'h0, 1'b0), o_ins, o_err, o_addr, o_wrap, lat);
            if (o_wrap) pulses++;
            checks++;
            if (o_addr !== exp_seq[i] || o_ins !== ((32'h00001000 * (i + 1)) | 32'h00000137)) begin
                errors++;
                $display("FAIL wrap_addr[%0d]: got addr=%0d ins=%h need addr=%0d ins=%h", i, o_addr,
                         o_ins, exp_seq[i], (32'h00001000 * (i + 1)) | 32'h00000137);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL wrap_pulses: got %0d need 1", pulses);
        end
        exp_addr = 2'd1;
    endtask

    task automatic test_async_reset();
        int n;
        ready_in = 1'b0;
        drive_req(mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd7, 32'h0, 1'b0));
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        n = 0;
        while (!valid_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (valid_out !== 1'b1 || ins !== 32'h00700093 || addr !== exp_addr) begin
            errors++;
            $display("FAIL areset_pre: valid=%b ins=%h addr=%0d need 1 00700093 %0d",
                     valid_out, ins, addr, exp_addr);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || addr !== '0 || ins !== 32'h0 || err !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: valid=%b addr=%0d ins=%h err=%b wrap=%b need all 0",
                     valid_out, addr, ins, err, wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ready_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL areset_after: valid=%b ready=%b need 0 1", valid_out, ready_out);
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_range();
        test_stall();
        test_clr();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
